// File: rtl/mem_march_tester.sv
// March BIST initiator for a single-port byte memory.
// Three march elements: W0 up, R0/W1 up, R1 down; checks every read.
module mem_march_tester #(
    parameter logic [7:0] ADDR_LAST = 8'd254,
    parameter logic [7:0] PATTERN   = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       mem_en,
    output logic       mem_rw,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0W1,
        S_R1,
        S_DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic       ph_q, ph_d;
    logic       chk_q, chk_d;
    logic [7:0] chk_addr_q, chk_addr_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_rw_q, mem_rw_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] err_count_q, err_count_d;
    logic [7:0] first_err_q, first_err_d;

    logic       cmp_en;
    logic [7:0] cmp_exp;
    logic [7:0] cmp_addr;
    logic       mismatch;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        chk_d       = chk_q;
        chk_addr_d  = chk_addr_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        cmp_en      = 1'b0;
        cmp_exp     = PATTERN;
        cmp_addr    = mem_addr_q;

        unique case (state_q)
            S_IDLE: begin
                mem_en_d = 1'b0;
                if (start) begin
                    state_d     = S_W0;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = 1'b1;
                    mem_addr_d  = 8'd0;
                    mem_wdata_d = PATTERN;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_count_d = 8'd0;
                    first_err_d = 8'd0;
                end
            end
            S_W0: begin
                if (mem_addr_q == ADDR_LAST) begin
                    state_d    = S_R0W1;
                    mem_addr_d = 8'd0;
                    mem_rw_d   = 1'b0;
                    ph_d       = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + 8'd1;
                end
            end
            S_R0W1: begin
                if (!ph_q) begin
                    ph_d        = 1'b1;
                    mem_rw_d    = 1'b1;
                    mem_wdata_d = ~PATTERN;
                end else begin
                    // read data for this address is on mem_rdata now
                    cmp_en   = 1'b1;
                    ph_d     = 1'b0;
                    mem_rw_d = 1'b0;
                    if (mem_addr_q == ADDR_LAST) begin
                        state_d    = S_R1;
                        mem_addr_d = ADDR_LAST;
                        chk_d      = 1'b0;
                    end else begin
                        mem_addr_d = mem_addr_q + 8'd1;
                    end
                end
            end
            S_R1: begin
                cmp_en     = chk_q;
                cmp_exp    = ~PATTERN;
                cmp_addr   = chk_addr_q;
                chk_d      = 1'b1;
                chk_addr_d = mem_addr_q;
                if (mem_addr_q == 8'd0) begin
                    state_d  = S_DRAIN;
                    mem_en_d = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q - 8'd1;
                end
            end
            S_DRAIN: begin
                cmp_en   = 1'b1;
                cmp_exp  = ~PATTERN;
                cmp_addr = chk_addr_q;
                state_d  = S_IDLE;
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mismatch = cmp_en && (mem_rdata != cmp_exp);
        if (mismatch) begin
            if (err_count_q == 8'd0) first_err_d = cmp_addr;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        if (state_q == S_DRAIN) pass_d = (err_count_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph_q        <= 1'b0;
            chk_q       <= 1'b0;
            chk_addr_q  <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 8'd0;
            first_err_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            chk_q       <= chk_d;
            chk_addr_q  <= chk_addr_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
        end
    end

    assign mem_en         = mem_en_q;
    assign mem_rw         = mem_rw_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_mem_march_tester.sv
// Directed bench for mem_march_tester with a behavioural byte memory
// that can model a stuck-at bit or disabled writes.
module tb_mem_march_tester;

    localparam int N = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mem_en, mem_rw;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'd0;
    logic       busy, done, pass;
    logic [7:0] err_count, first_err_addr;

    logic [7:0] mem [256];
    int         fault = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    mem_march_tester dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) begin
                if (fault != 2) mem[mem_addr] <= mem_wdata;
            end else begin
                if (fault == 2)
                    mem_rdata <= 8'h00;
                else if (fault == 1 && mem_addr == 8'h37)
                    mem_rdata <= mem[mem_addr] & 8'hFE;
                else
                    mem_rdata <= mem[mem_addr];
            end
        end
    end

    // Start a test (unless already requested) and watch the bus until done.
    task automatic run(input bit pre, input int hold, input int extra_at,
                       input bit chain, output int busy_n,
                       output int done_n, output int ord_err,
                       output bit tmo);
        int done_c;
        bit en_e, rw_e;
        logic [7:0] a_e, d_e;
        busy_n = 0; done_n = 0; ord_err = 0; tmo = 1'b1; done_c = 0;
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk); #1;
        for (int c = 0; c < 6000; c++) begin
            start = ((c + 1) < hold) || (c == extra_at);
            if (busy) begin
                busy_n++;
                en_e = 1'b1; rw_e = 1'b0; a_e = 8'd0; d_e = 8'hxx;
                if (c < N) begin
                    rw_e = 1'b1; a_e = 8'(c); d_e = 8'h55;
                end else if (c < 3 * N) begin
                    a_e = 8'((c - N) / 2); rw_e = ((c - N) % 2) == 1;
                    if (rw_e) d_e = 8'hAA;
                end else if (c < 4 * N) begin
                    a_e = 8'(254 - (c - 3 * N));
                end else begin
                    en_e = 1'b0;
                end
                if (mem_en !== en_e) ord_err++;
                else if (en_e && (mem_rw !== rw_e || mem_addr !== a_e)) ord_err++;
                else if (en_e && rw_e && mem_wdata !== d_e) ord_err++;
            end
            if (done) begin
                if (done_n == 0) done_c = c;
                done_n++;
                tmo = 1'b0;
                if (chain) begin
                    start = 1'b1;
                    return;
                end
            end
            if (!tmo && c > done_c + 3) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++;
        if ({mem_en, mem_rw, busy, done, pass} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_en, mem_rw, busy, done, pass});
        end
        n_assert++;
        if ({mem_addr, mem_wdata, err_count, first_err_addr} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h want 0",
                     {mem_addr, mem_wdata, err_count, first_err_addr});
        end
    endtask

    task automatic test_clean();
        int b, d, o, bad;
        bit t;
        fault = 0;
        run(1'b0, 1, -1, 1'b0, b, d, o, t);
        n_assert++;
        if (t) begin n_fail++; $display("FAIL clean_timeout: no done"); end
        n_assert++;
        if (b != 1021) begin n_fail++; $display("FAIL clean_busy: got %0d want 1021", b); end
        n_assert++;
        if (d != 1) begin n_fail++; $display("FAIL clean_done: got %0d want 1", d); end
        n_assert++;
        if (o != 0) begin n_fail++; $display("FAIL clean_order: got %0d errors want 0", o); end
        n_assert++;
        if (pass !== 1'b1 || err_count !== 8'd0 || first_err_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL clean_result: got pass=%b err=%0d first=%h want 1 0 00",
                     pass, err_count, first_err_addr);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 8'hAA) bad++;
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL clean_mem: got %0d bytes not AA want 0", bad); end
    endtask

    task automatic test_stuck_bit();
        int b, d, o;
        bit t;
        fault = 1;
        run(1'b0, 1, -1, 1'b0, b, d, o, t);
        n_assert++;
        if (t || pass !== 1'b0) begin
            n_fail++; $display("FAIL stuck_pass: got %b tmo=%b want 0", pass, t);
        end
        n_assert++;
        if (err_count !== 8'd1) begin
            n_fail++; $display("FAIL stuck_count: got %0d want 1", err_count);
        end
        n_assert++;
        if (first_err_addr !== 8'h37) begin
            n_fail++; $display("FAIL stuck_addr: got %h want 37", first_err_addr);
        end
        fault = 0;
    endtask

    task automatic test_all_zero();
        int b, d, o;
        bit t;
        fault = 2;
        run(1'b0, 1, -1, 1'b0, b, d, o, t);
        n_assert++;
        if (t || err_count !== 8'd255) begin
            n_fail++; $display("FAIL zero_count: got %0d want 255", err_count);
        end
        n_assert++;
        if (first_err_addr !== 8'h00 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result: got first=%h pass=%b want 00 0",
                     first_err_addr, pass);
        end
        fault = 0;
    endtask

    task automatic test_rst_mid();
        int b, d, o, dn, en_n;
        bit t;
        fault = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (299) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_assert++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got en=%b busy=%b done=%b want 0 0 0",
                     mem_en, busy, done);
        end
        dn = 0; en_n = 0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
            if (mem_en) en_n++;
        end
        n_assert++;
        if (dn != 0 || en_n != 0) begin
            n_fail++; $display("FAIL rst_quiet: got done=%0d en=%0d want 0 0", dn, en_n);
        end
        run(1'b0, 1, -1, 1'b0, b, d, o, t);
        n_assert++;
        if (t || pass !== 1'b1 || b != 1021) begin
            n_fail++; $display("FAIL rst_rerun: got pass=%b busy=%0d want 1 1021", pass, b);
        end
    endtask

    task automatic test_start_held();
        int b, d, o;
        bit t;
        run(1'b0, 10, 500, 1'b0, b, d, o, t);
        n_assert++;
        if (t || b != 1021 || d != 1) begin
            n_fail++;
            $display("FAIL held_start: got busy=%0d done=%0d want 1021 1", b, d);
        end
        n_assert++;
        if (o != 0 || pass !== 1'b1) begin
            n_fail++; $display("FAIL held_order: got err=%0d pass=%b want 0 1", o, pass);
        end
    endtask

    task automatic test_back_to_back();
        int b, d, o;
        bit t;
        run(1'b0, 1, -1, 1'b1, b, d, o, t);
        run(1'b1, 1, -1, 1'b0, b, d, o, t);
        n_assert++;
        if (t || b != 1021 || d != 1 || o != 0) begin
            n_fail++;
            $display("FAIL b2b: got busy=%0d done=%0d ord=%0d want 1021 1 0", b, d, o);
        end
        n_assert++;
        if (pass !== 1'b1 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL b2b_result: got pass=%b err=%0d want 1 0", pass, err_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_clean();
        test_stuck_bit();
        test_all_zero();
        test_rst_mid();
        test_start_held();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_march_tester.md
# mem_march_tester

Built-in self-test initiator for the single-port 8-bit byte memory. Drives the memory's enable, read/write, address and write-data lines. Runs a three-element march test (write pattern ascending; read-pattern/write-complement ascending; read-complement descending) and checks every read value. Reports pass/fail, error count and first failing address. Sits between the test/bring-up logic and the memory, on the initiating (Test) side of the control bus.

## Interface
- ADDR_LAST, 254: highest address exercised. Addresses 0..ADDR_LAST, so N = ADDR_LAST+1. Must be ≥ 1.
- PATTERN, 8'h55: background data pattern. Its complement is ~PATTERN.

- clk  in  1  clock; all activity on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mem_en  out  1  memory enable (control bus en).
- mem_rw  out  1  1 = write, 0 = read (control bus rw).
- mem_addr  out  8  memory address.
- mem_wdata  out  8  write data; meaningful only when mem_en & mem_rw.
- mem_rdata  in  8  read data from memory; valid the cycle after the edge that sampled a read.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test completion.
- pass  out  1  result of the last completed test; held until next start.
- err_count  out  8  mismatches in the current/last test; saturates at 255.
- first_err_addr  out  8  address of the first mismatch; 0 if none.

## Operation
- All outputs are registered.
- Reset values: mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0. State = IDLE.
- States: IDLE → W0 → R0W1 → R1 → DRAIN → IDLE.
- **IDLE:** mem_en=0. When start=1, the next edge:
  - enters W0 with addr=0;
  - sets busy=1;
  - clears pass, err_count and first_err_addr.
- **W0:** one write per cycle of PATTERN, addr 0..ADDR_LAST ascending. After ADDR_LAST, go to R0W1 with addr=0.
- **R0W1:** two cycles per address, ascending.
  - Read cycle: mem_en=1, mem_rw=0.
  - Write cycle: mem_en=1, mem_rw=1, data ~PATTERN, same address.
  - During the write cycle, mem_rdata holds the read result. It is compared against PATTERN at the end of that cycle.
  - After the write to ADDR_LAST, go to R1 with addr=ADDR_LAST.
- **R1:** one read per cycle, addr ADDR_LAST down to 0. Pipelined compare: the value read for address a is checked against ~PATTERN one cycle later, with the registered address a. After reading addr 0, go to DRAIN.
- **DRAIN:** mem_en=0. Checks the final read (addr 0). On the next edge:
  - go to IDLE;
  - done=1 for one cycle, busy=0;
  - pass = (err_count==0 including this final compare).
- **Mismatch handling:**
  - err_count increments, saturating at 255.
  - On the first mismatch of a test, first_err_addr captures the address whose read failed.
  - Later mismatches do not change first_err_addr.
- **Address counter:** 8-bit. Must not wrap past ADDR_LAST or below 0; direction changes are only at state transitions.
- **start while busy:** ignored; no restart, no effect on counters.
- **rst mid-test:** next edge forces the reset values. mem_en drops immediately, so no further writes are issued. done is not pulsed. Memory contents are left as-is.
- **start and rst together:** rst wins.

## Timing
- Let edge 0 be the edge that samples start.
- mem_en is first high in the cycle after edge 0, with addr 0 and W0 data.
- Write accesses land at edges 1..N.
- R0W1 occupies the cycles after edges N..3N-1.
- R1 reads occupy the cycles after edges 3N..4N-1.
- DRAIN is the cycle after edge 4N.
- done, and the final pass/err_count, are visible after edge 4N+1: 1021 cycles for N=255.
- busy is high for exactly 4N+1 cycles.
- Memory utilisation is one access per cycle throughout; mem_en is never low while busy except in DRAIN.
- Back-to-back operation: start may be asserted in the cycle done is high. The FSM is already in IDLE then, so the new test begins at the next edge.

## Test plan
- **Fault-free memory, defaults:** pulse start → busy high 1021 cycles; done pulse; pass=1, err_count=0, first_err_addr=0. Memory ends holding 8'hAA everywhere.
- **Stuck-at-0 on bit 0 at address 8'h37:** → pass=0 and first_err_addr=8'h37. err_count=1: the R0W1 read of 8'h55 fails and the R1 read of 8'hAA passes. Adjust the expected count to the fault model used.
- **Every read returns 8'h00 (memory writes disabled):** → err_count=255 (saturated), first_err_addr=0, pass=0.
- **Ordering check:** monitor the bus → W0 addresses 0..254 all with data 8'h55. R0W1 alternates read/write per address with write data 8'hAA. R1 addresses 254 down to 0, reads only.
- **rst asserted 300 cycles after start:** → next cycle mem_en=0, busy=0, no done pulse. A subsequent start runs a full clean test with pass=1.
- **start held high for 10 cycles, then a second start mid-test:** → exactly one test of 1021 cycles and exactly one done pulse.
